// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder transmitter.
package spi_pkg;

    localparam int FRAME_BITS_DEF = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Counter must reach FRAME_BITS itself, hence the +1.
    function automatic int cnt_w(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with one-cycle rise/fall pulses on the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    localparam logic [STAGES:0] ONE = 1;

    logic            q;
    logic            prev;
    logic [STAGES:0] vld_pipe;

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= {STAGES{RST_VAL}};
                end else begin
                    sync_q[0] <= d;
                    for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign q = sync_q[STAGES-1];
        end
    endgenerate

    // Edges are suppressed until both q and prev carry real samples, so the
    // reset value never forms a fake edge against the pin after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= RST_VAL;
            vld_pipe <= '0;
        end else begin
            prev     <= q;
            vld_pipe <= (vld_pipe << 1) | ONE;
        end
    end

    assign rise = vld_pipe[STAGES] &  q & ~prev;
    assign fall = vld_pipe[STAGES] & ~q &  prev;

endmodule

// File: rtl/spi_resp_tx.sv
// SPI mode-0 responder: shifts a held frame out on MISO, MSB first, under master SS/SCLK.
module spi_resp_tx
    import spi_pkg::*;
#(
    parameter int                    FRAME_BITS  = FRAME_BITS_DEF,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [FRAME_BITS-1:0] RESET_DATA  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss,
    input  logic                  sclk,
    output logic                  miso,
    input  logic [FRAME_BITS-1:0] din,
    input  logic                  din_valid,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int            CW   = cnt_w(FRAME_BITS);
    localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

    logic ss_rise, ss_fall, sclk_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ss),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sclk),
        .rise (),
        .fall (sclk_fall)
    );

    state_t                state, state_nxt;
    logic [FRAME_BITS-1:0] hold, shift, shift_nxt;
    logic [CW-1:0]         bit_cnt, cnt_nxt;
    logic                  busy_nxt, done_nxt, err_nxt, miso_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold       <= RESET_DATA;
            shift      <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            miso       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            bit_cnt    <= cnt_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
            miso       <= miso_nxt;
            if (din_valid) hold <= din;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        cnt_nxt   = bit_cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        miso_nxt  = (state == SHIFT) & shift[FRAME_BITS-1];
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    shift_nxt = hold;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // SS rise takes priority over a coincident SCLK fall.
                if (ss_rise) begin
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (sclk_fall) begin
                    shift_nxt = shift << 1;
                    cnt_nxt   = bit_cnt + CW'(1);
                    if (bit_cnt == LAST) state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ss_rise) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_resp_tx.sv
// Directed bench: one synchronised instance and one bypass instance of spi_resp_tx.
module tb_spi_resp_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ss0 = 1'b1, sclk0 = 1'b0, ss1 = 1'b1, sclk1 = 1'b0;
    logic [39:0] din = '0;
    logic        din_valid = 1'b0;
    logic        miso0, busy0, frame_done0, frame_err0;
    logic        miso1, busy1, frame_done1, frame_err1;

    int errors = 0;
    int checks = 0;
    int done0 = 0, err0 = 0, done1 = 0, err1 = 0;
    logic [63:0] got;

    always #5 clk = ~clk;

    spi_resp_tx #(.FRAME_BITS(40), .SYNC_STAGES(2), .RESET_DATA(40'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ss(ss0), .sclk(sclk0), .miso(miso0),
        .din(din), .din_valid(din_valid), .busy(busy0),
        .frame_done(frame_done0), .frame_err(frame_err0)
    );

    spi_resp_tx #(.FRAME_BITS(40), .SYNC_STAGES(0), .RESET_DATA(40'h0)) dut1 (
        .clk(clk), .rst_n(rst_n), .ss(ss1), .sclk(sclk1), .miso(miso1),
        .din(din), .din_valid(din_valid), .busy(busy1),
        .frame_done(frame_done1), .frame_err(frame_err1)
    );

    always @(posedge clk) begin
        if (frame_done0) done0++;
        if (frame_err0)  err0++;
        if (frame_done1) done1++;
        if (frame_err1)  err1++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [39:0] v);
        din = v; din_valid = 1'b1;
        @(posedge clk); #1 din_valid = 1'b0;
    endtask

    task automatic ss_set(input bit byp, input logic v);
        if (byp) ss1 = v; else ss0 = v;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Each SCLK phase lasts ph clk edges; miso is sampled late in the high phase.
    task automatic pulses(input bit byp, input int n, input int ph, output logic [63:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            if (byp) sclk1 = 1'b1; else sclk0 = 1'b1;
            repeat (ph - 1) @(posedge clk);
            @(negedge clk);
            bits = {bits[62:0], (byp ? miso1 : miso0)};
            @(posedge clk); #1;
            if (byp) sclk1 = 1'b0; else sclk0 = 1'b0;
            repeat (ph) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_miso", miso0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", frame_done0, 0);
        check("rst_err", frame_err0, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Basic frame with latency checks around SS edges
        load(40'hA512345678);
        ss0 = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("busy_pre", busy0, 0);
        @(posedge clk); #1;
        check("busy_on", busy0, 1);
        check("miso_pre", miso0, 0);
        @(posedge clk); #1;
        check("first_bit", miso0, 1);
        repeat (4) @(posedge clk); #1;
        pulses(0, 40, 4, got);
        check("basic_data", got[39:0], 40'hA512345678);
        ss0 = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("done_pre", frame_done0, 0);
        check("busy_hold", busy0, 1);
        @(posedge clk); #1;
        check("done_pulse", frame_done0, 1);
        check("busy_off", busy0, 0);
        @(posedge clk); #1;
        check("done_end", frame_done0, 0);
        repeat (4) @(posedge clk); #1;
        check("basic_done_cnt", done0, 1);
        check("basic_err_cnt", err0, 0);

        // Short frame of 17 bits, then a full one from bit 39
        ss_set(0, 1'b0);
        pulses(0, 17, 4, got);
        check("short_data", got[16:0], 64'h14A24);
        ss_set(0, 1'b1);
        check("short_err_cnt", err0, 1);
        check("short_done_cnt", done0, 1);
        check("short_miso", miso0, 0);
        check("short_busy", busy0, 0);
        ss_set(0, 1'b0);
        pulses(0, 40, 4, got);
        check("after_short", got[39:0], 40'hA512345678);
        ss_set(0, 1'b1);
        check("after_short_done", done0, 2);

        // din_valid coincident with the detected SS fall belongs to the next frame
        load(40'h1111111111);
        ss0 = 1'b0;
        repeat (2) @(posedge clk); #1;
        din = 40'hFFFFFFFFFF; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (5) @(posedge clk); #1;
        pulses(0, 40, 4, got);
        check("reload_old", got[39:0], 40'h1111111111);
        ss_set(0, 1'b1);
        ss_set(0, 1'b0);
        pulses(0, 40, 4, got);
        check("reload_new", got[39:0], 40'hFFFFFFFFFF);
        ss_set(0, 1'b1);
        check("reload_done", done0, 4);

        // 45 pulses: bits 41-45 read as zero and the frame still completes
        ss_set(0, 1'b0);
        pulses(0, 45, 4, got);
        check("extra_data", got[44:5], 40'hFFFFFFFFFF);
        check("extra_tail", got[4:0], 0);
        ss_set(0, 1'b1);
        check("extra_done", done0, 5);
        check("extra_err", err0, 1);

        // Reset after 20 bits, released with SS still low
        ss_set(0, 1'b0);
        pulses(0, 20, 4, got);
        check("pre_rst_miso", miso0, 1);
        rst_n = 1'b0;
        #2;
        check("async_miso", miso0, 0);
        check("async_busy", busy0, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("rel_busy", busy0, 0);
        check("rel_miso", miso0, 0);
        ss_set(0, 1'b1);
        check("rel_err", err0, 1);
        check("rel_done", done0, 5);
        ss_set(0, 1'b0);
        check("rel_busy_new", busy0, 1);
        pulses(0, 40, 4, got);
        check("rst_hold", got[39:0], 40'h0);
        ss_set(0, 1'b1);
        check("rst_frame_done", done0, 6);

        // Bypass instance with 2-clk SCLK phases
        load(40'hC3C3C3C3C3);
        ss1 = 1'b0;
        @(posedge clk); #1;
        check("byp_busy", busy1, 1);
        check("byp_miso_pre", miso1, 0);
        @(posedge clk); #1;
        check("byp_first_bit", miso1, 1);
        repeat (4) @(posedge clk); #1;
        pulses(1, 40, 2, got);
        check("byp_data", got[39:0], 40'hC3C3C3C3C3);
        ss1 = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("byp_done", done1, 1);
        check("byp_err", err1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_resp_tx.md
Name: spi_resp_tx

Overview:
- SPI responder (slave-side transmitter) for the 40-bit, 5-byte joystick-style frame.
- Shifts a parallel-loaded word out on MISO, MSB first, while an external master drives SS and SCLK.
- Used as an on-board emulator of the sensor and as the far end for closed-loop checks of the SPI receive controller.
- SPI mode 0: MISO changes after SCLK falling edges; the master samples while SCLK is high.

Parameters:
- FRAME_BITS, 40: bits per frame.
- SYNC_STAGES, 2: flip-flops per synchroniser on SS and SCLK. 0 means the inputs are already in the clk domain (bypass).
- RESET_DATA, 40'h0: hold-register value after reset.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ss  input  1  slave select from master, active low.
- sclk  input  1  serial clock from master.
- miso  output  1  serial data to master.
- din  input  FRAME_BITS  next frame payload.
- din_valid  input  1  load strobe for din.
- busy  output  1  high while a frame is in progress (SS low).
- frame_done  output  1  one-cycle pulse: frame completed with exactly FRAME_BITS shifts.
- frame_err  output  1  one-cycle pulse: SS deasserted before FRAME_BITS shifts.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: miso=0, busy=0, frame_done=0, frame_err=0, hold=RESET_DATA, shift=0, bit_cnt=0, state=IDLE. Synchronisers reset to ss=1, sclk=0.
- Reset mid-frame: abort immediately, no pulse. After release, stay in IDLE until a new SS falling edge; an SS already low at release is not a frame start.
- Synchronisers: ss and sclk each pass SYNC_STAGES flops, then a one-flop edge detector.
- Master timing: SCLK high and low phases each ≥ SYNC_STAGES+2 clk cycles. No SCLK edges while SS is high.
- Hold register: loads din on any cycle with din_valid=1; last write wins. No back-pressure; din is accepted in any state.
  - The shift register copies hold on SS fall.
  - A din_valid in the same cycle as the detected SS fall is not used for that frame; it is used for the next one.
- IDLE: miso=0, busy=0. On SS fall: shift<=hold, bit_cnt<=0, busy<=1, go to SHIFT.
- miso is registered and equals shift[FRAME_BITS-1] in SHIFT. The first bit appears SYNC_STAGES+2 clk after the SS pin falls.
- SHIFT, on each detected SCLK falling edge:
  - shift<=shift<<1 and bit_cnt<=bit_cnt+1.
  - If bit_cnt==FRAME_BITS-1, go to HOLD.
  - The next bit appears on miso SYNC_STAGES+2 clk after the SCLK pin falls.
- SCLK rising edges are ignored; no MOSI input exists.
- HOLD: miso=0. Further SCLK edges are ignored, with no wrap and no counter change.
- On SS rise:
  - From HOLD: frame_done pulse, go to IDLE.
  - From SHIFT: frame_err pulse, go to IDLE.
  - busy<=0 on the same cycle as the pulse.
- Simultaneous detected SCLK fall and SS rise: SS rise wins; no shift, counter unchanged for the error decision.
- bit_cnt width is $clog2(FRAME_BITS+1) and it saturates at FRAME_BITS.
- frame_done and frame_err are mutually exclusive and never asserted during reset.

Decomposition:
- Package spi_pkg:
  - FRAME_BITS default constant.
  - State enum: IDLE, SHIFT, HOLD, 2-bit.
  - Bit-counter width localparam function.
- Sub-module spi_sync_edge:
  - Synchroniser of SYNC_STAGES flops plus rise/fall pulse outputs, with reset value as a parameter.
  - Instantiated twice, once for SS and once for SCLK.

Test Plan:
- Basic frame: load din=40'hA5_12_34_56_78, then SS low and 40 SCLK pulses (4 clk high / 4 clk low). Bits sampled on SCLK high reconstruct 40'hA512345678; frame_done pulses once 3 clk after SS rise; busy is high from SS fall+3 clk until the pulse.
- Short frame: SS low, 17 SCLK pulses, SS high. frame_err pulses once, frame_done stays 0, miso returns to 0. The next full frame sends the complete hold value from bit 39.
- Extra clocks: 45 SCLK pulses in one frame. The first 40 bits are correct; miso=0 for pulses 41-45; frame_done is still asserted.
- Reload timing: din=40'h1111111111 earlier, din=40'hFFFFFFFFFF with din_valid in the same cycle as the detected SS fall. The frame carries 40'h1111111111; the next frame carries 40'hFFFFFFFFFF.
- Reset mid-frame: assert rst_n=0 after 20 bits. All outputs drop to 0 asynchronously and hold returns to RESET_DATA. After release with SS still low, no pulses and miso=0 until SS rises and falls again.
- Bypass mode: SYNC_STAGES=0 with SCLK phases of 2 clk. 40'hC3C3C3C3C3 is received intact; first-bit latency is 2 clk after SS fall.
